// File: rtl/cpu_step_ctrl_pkg.sv
// Shared constants for the CPU step controller: state encoding and default sizing.
package cpu_step_ctrl_pkg;

  localparam logic [1:0] ST_HALT = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_STEP = 2'b10;

  localparam int DEF_DEBOUNCE_CYCLES = 250000;
  localparam int DEF_CNT_W           = 16;

endpackage

// File: rtl/cpu_step_ctrl_if.sv
// Core-facing bundle: halt request in, clock enable and status out.
interface cpu_step_ctrl_if
  import cpu_step_ctrl_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
);
  logic             halt_req;
  logic             cpu_en;
  logic             running;
  logic             halted;
  logic [CNT_W-1:0] instr_cnt;

  modport master (input halt_req, output cpu_en, running, halted, instr_cnt);
  modport slave  (output halt_req, input cpu_en, running, halted, instr_cnt);
endinterface

// File: rtl/cpu_step_ctrl_btn_debounce.sv
// Push-button conditioner: 2-flop synchroniser, hold-time debounce and press pulse.
module btn_debounce
  import cpu_step_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press
);
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          b1, b2;
  logic          stable, stable_d;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b1       <= 1'b0;
      b2       <= 1'b0;
      stable   <= 1'b0;
      stable_d <= 1'b0;
      cnt      <= '0;
    end else begin
      b1       <= btn;
      b2       <= b1;
      stable_d <= stable;
      // Level must differ for DEBOUNCE_CYCLES consecutive cycles to be accepted
      if (b2 == stable) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        stable <= b2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign press = stable & ~stable_d;

endmodule

// File: rtl/cpu_step_ctrl.sv
// Converts slow_clk ticks (run mode) or debounced step presses into single-cycle core enables.
module cpu_step_ctrl
  import cpu_step_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            slow_clk,
  input  logic            mode_run,
  input  logic            step_btn,
  cpu_step_ctrl_if.master core
);
  logic             s1, s2, prev;
  logic             tick;
  logic             step_req;
  logic [1:0]       state;
  logic             en_q;
  logic             halted_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      prev <= 1'b0;
    end else begin
      s1   <= slow_clk;
      s2   <= s1;
      prev <= s2;
    end
  end

  assign tick = s2 & ~prev;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_step_btn (
    .clk  (clk),
    .rst_n(rst_n),
    .btn  (step_btn),
    .press(step_req)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_HALT;
      en_q     <= 1'b0;
      halted_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      en_q <= 1'b0;
      if (en_q) cnt_q <= cnt_q + CNT_W'(1);
      if (!mode_run && !halt_req_w()) halted_q <= 1'b0;
      case (state)
        ST_HALT: begin
          if (mode_run && !halted_q && !core.halt_req) state <= ST_RUN;
          else if (step_req && !halted_q)             state <= ST_STEP;
        end
        ST_RUN: begin
          // Halt outranks a same-cycle tick
          if (core.halt_req) begin
            state    <= ST_HALT;
            halted_q <= 1'b1;
          end else if (!mode_run) begin
            state <= ST_HALT;
          end else if (tick) begin
            en_q <= 1'b1;
          end
        end
        ST_STEP: begin
          en_q  <= 1'b1;
          state <= ST_HALT;
          if (core.halt_req) halted_q <= 1'b1;
        end
        default: state <= ST_HALT;
      endcase
    end
  end

  function automatic logic halt_req_w();
    return core.halt_req;
  endfunction

  assign core.cpu_en    = en_q;
  assign core.running   = (state == ST_RUN);
  assign core.halted    = halted_q;
  assign core.instr_cnt = cnt_q;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Scoreboard bench for cpu_step_ctrl: 16-bit and 4-bit counter instances share stimulus.
module tb_cpu_step_ctrl;
  localparam int DEB = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic slow_clk;
  logic mode_run;
  logic step_btn;
  logic halt_req;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;
  int model_cnt = 0;
  int exp_q[$];
  logic prev_en = 1'b0;

  cpu_step_ctrl_if #(.CNT_W(16)) bus16 ();
  cpu_step_ctrl_if #(.CNT_W(4))  bus4 ();

  assign bus16.halt_req = halt_req;
  assign bus4.halt_req  = halt_req;

  cpu_step_ctrl #(.DEBOUNCE_CYCLES(DEB), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .slow_clk(slow_clk), .mode_run(mode_run),
    .step_btn(step_btn), .core(bus16)
  );

  cpu_step_ctrl #(.DEBOUNCE_CYCLES(DEB), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .slow_clk(slow_clk), .mode_run(mode_run),
    .step_btn(step_btn), .core(bus4)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  // Every observed enable must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst_n && bus16.cpu_en) begin
      chk("en_gap", {31'd0, prev_en}, 0);
      if (exp_q.size() == 0) begin
        chk("spurious_en", {31'd0, bus16.cpu_en}, 0);
      end else begin
        int e;
        e = exp_q.pop_front();
        chk("en_cycle", cyc, e);
      end
    end
    prev_en = bus16.cpu_en;
  end

  task automatic wait_clk(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic slow_period(input bit expect_pulse);
    slow_clk = 1'b1;
    if (expect_pulse) begin
      exp_q.push_back(cyc + 3);
      model_cnt++;
    end
    wait_clk(20);
    slow_clk = 1'b0;
    wait_clk(20);
  endtask

  task automatic check_counts(input string tag);
    logic [15:0] m16;
    logic [3:0]  m4;
    m16 = 16'(model_cnt);
    m4  = 4'(model_cnt);
    chk({tag, "_pending"}, exp_q.size(), 0);
    chk({tag, "_cnt16"}, {16'd0, bus16.instr_cnt}, {16'd0, m16});
    chk({tag, "_cnt4"}, {28'd0, bus4.instr_cnt}, {28'd0, m4});
  endtask

  initial begin
    rst_n    = 1'b0;
    slow_clk = 1'b0;
    mode_run = 1'b0;
    step_btn = 1'b0;
    halt_req = 1'b0;
    wait_clk(3);
    chk("rst_en", {31'd0, bus16.cpu_en}, 0);
    chk("rst_running", {31'd0, bus16.running}, 0);
    chk("rst_halted", {31'd0, bus16.halted}, 0);
    chk("rst_cnt", {16'd0, bus16.instr_cnt}, 0);
    rst_n = 1'b1;
    wait_clk(2);

    // Free-run: four rising edges of slow_clk
    mode_run = 1'b1;
    wait_clk(2);
    chk("fr_running", {31'd0, bus16.running}, 1);
    for (int i = 0; i < 4; i++) slow_period(1'b1);
    wait_clk(5);
    check_counts("fr");
    chk("fr_running_end", {31'd0, bus16.running}, 1);

    // Debounced step with bounce
    mode_run = 1'b0;
    wait_clk(3);
    chk("st_running", {31'd0, bus16.running}, 0);
    for (int i = 0; i < 5; i++) begin
      step_btn = (i % 2 == 0);
      if (i == 4) begin
        exp_q.push_back(cyc + DEB + 4);
        model_cnt++;
      end
      wait_clk(1);
    end
    wait_clk(20);
    step_btn = 1'b0;
    wait_clk(20);
    check_counts("st");

    // Short glitch must be rejected
    step_btn = 1'b1;
    wait_clk(6);
    step_btn = 1'b0;
    wait_clk(20);
    chk("gl_running", {31'd0, bus16.running}, 0);
    check_counts("gl");

    // Halt request coinciding with a tick
    mode_run = 1'b1;
    wait_clk(2);
    chk("hp_running_pre", {31'd0, bus16.running}, 1);
    slow_clk = 1'b1;
    wait_clk(2);
    halt_req = 1'b1;
    wait_clk(1);
    chk("hp_halted", {31'd0, bus16.halted}, 1);
    chk("hp_running", {31'd0, bus16.running}, 0);
    wait_clk(2);
    halt_req = 1'b0;
    wait_clk(15);
    slow_clk = 1'b0;
    wait_clk(20);
    slow_period(1'b0);
    slow_period(1'b0);
    step_btn = 1'b1;
    wait_clk(20);
    step_btn = 1'b0;
    wait_clk(20);
    chk("hp_halted_hold", {31'd0, bus16.halted}, 1);
    chk("hp_running_hold", {31'd0, bus16.running}, 0);
    check_counts("hp");
    mode_run = 1'b0;
    wait_clk(2);
    chk("hp_rearm", {31'd0, bus16.halted}, 0);

    // Asynchronous reset in the middle of a pulse
    mode_run = 1'b1;
    wait_clk(2);
    slow_clk = 1'b1;
    exp_q.push_back(cyc + 3);
    model_cnt++;
    wait_clk(3);
    chk("ar_pre_en", {31'd0, bus16.cpu_en}, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("ar_en", {31'd0, bus16.cpu_en}, 0);
    chk("ar_running", {31'd0, bus16.running}, 0);
    chk("ar_halted", {31'd0, bus16.halted}, 0);
    chk("ar_cnt16", {16'd0, bus16.instr_cnt}, 0);
    chk("ar_en4", {31'd0, bus4.cpu_en}, 0);
    chk("ar_running4", {31'd0, bus4.running}, 0);
    chk("ar_halted4", {31'd0, bus4.halted}, 0);
    chk("ar_cnt4", {28'd0, bus4.instr_cnt}, 0);
    exp_q.delete();
    model_cnt = 0;
    slow_clk = 1'b0;
    wait_clk(2);
    rst_n = 1'b1;
    wait_clk(1);
    chk("ar_resume", {31'd0, bus16.running}, 1);

    // Counter wrap on the 4-bit instance
    for (int i = 0; i < 17; i++) slow_period(1'b1);
    wait_clk(5);
    check_counts("wrap");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
